// File: rtl/stump_mem_responder.sv
// Stump word memory: 2**ADDR_BITS x 16 RAM, ready after WAIT_CYCLES+1 cycles; requests are held until mem_ready.
// Define STUMP_MEM_IOPORT_EN to map a 16-bit io_port register at address 16'hFFFF.
module stump_mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy,
    output logic [15:0] io_port
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int         DEPTH     = 2 ** ADDR_BITS;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q;
    logic [15:0] wdat_q;
    logic        ren_q;
    logic        wen_q;
    logic [15:0] data_out_q;
    logic        mem_ready_q;
    logic        mem_err_q;
    logic [15:0] mem_q [DEPTH];

    logic        req;
    logic        go_resp;
    logic        acc_ren;
    logic        acc_wen;
    logic [15:0] acc_addr;
    logic        acc_in_range;
    logic        acc_io;
    logic        acc_err;
    logic [15:0] acc_rdat;
    logic [15:0] io_rdat;
    logic        lat_in_range;
    logic        mem_commit;

    assign req = mem_ren || mem_wen;

    // With zero wait states the access is decoded straight from the live inputs in IDLE.
    assign acc_ren  = (state_q == S_IDLE) ? mem_ren : ren_q;
    assign acc_wen  = (state_q == S_IDLE) ? mem_wen : wen_q;
    assign acc_addr = (state_q == S_IDLE) ? address : addr_q;

    assign acc_in_range = (acc_addr >> ADDR_BITS) == 16'h0000;
    assign lat_in_range = (addr_q >> ADDR_BITS) == 16'h0000;
    assign acc_err      = (acc_ren && acc_wen) || (!acc_in_range && !acc_io);

    assign go_resp = ((state_q == S_IDLE) && req && (WAIT_CYCLES == 0))
                  || ((state_q == S_WAIT) && (cnt_q == 4'd0));

    always_comb begin
        acc_rdat = 16'h0000;
        if (acc_io) begin
            acc_rdat = io_rdat;
        end else if (acc_in_range) begin
            acc_rdat = mem_q[acc_addr[ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdat_q      <= 16'h0000;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            data_out_q  <= 16'h0000;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_ready_q <= go_resp;
            mem_err_q   <= go_resp && acc_err;
            if (go_resp && acc_ren && !acc_wen) begin
                data_out_q <= acc_rdat;
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q <= address;
                        wdat_q <= data_in;
                        ren_q  <= mem_ren;
                        wen_q  <= mem_wen;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Writes land on the edge leaving RESP, so a reset inside the access drops them.
    assign mem_commit = (state_q == S_RESP) && wen_q && !ren_q && lat_in_range;

    always_ff @(posedge clk) begin
        if (!rst && mem_commit) begin
            mem_q[addr_q[ADDR_BITS-1:0]] <= wdat_q;
        end
    end

`ifdef STUMP_MEM_IOPORT_EN
    logic [15:0] io_port_q;
    logic        io_commit;

    assign acc_io    = (acc_addr == 16'hFFFF);
    assign io_commit = (state_q == S_RESP) && wen_q && !ren_q && (addr_q == 16'hFFFF);
    assign io_rdat   = io_port_q;
    assign io_port   = io_port_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            io_port_q <= 16'h0000;
        end else if (io_commit) begin
            io_port_q <= wdat_q;
        end
    end
`else
    assign acc_io  = 1'b0;
    assign io_rdat = 16'h0000;
    assign io_port = 16'h0000;
`endif

    assign data_out  = data_out_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_stump_mem_responder.sv
// Directed bench: three responders (WAIT_CYCLES 1, 0, 3) exercised with hand-computed expectations.
module tb_stump_mem_responder;
    logic        clk = 1'b0;
    logic        rst  [3];
    logic        ren  [3];
    logic        wen  [3];
    logic [15:0] addr [3];
    logic [15:0] din  [3];
    logic [15:0] dout [3];
    logic        rdy  [3];
    logic        err  [3];
    logic        bsy  [3];
    logic [15:0] iop  [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cap_dout;
    logic        cap_err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stump_mem_responder #(
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .ADDR_BITS  (8)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .mem_ren  (ren[g]),
            .mem_wen  (wen[g]),
            .address  (addr[g]),
            .data_in  (din[g]),
            .data_out (dout[g]),
            .mem_ready(rdy[g]),
            .mem_err  (err[g]),
            .busy     (bsy[g]),
            .io_port  (iop[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until mem_ready, capture the response, then return to IDLE.
    task automatic access(input int g, input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input string tag);
        int wc;
        wc = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        ren[g] = r; wen[g] = w; addr[g] = a; din[g] = d;
        for (int i = 0; i < wc; i++) begin
            tick();
            check({tag, "/early"}, 16'(rdy[g]), 16'h0000);
        end
        tick();
        check({tag, "/ready"}, 16'(rdy[g]), 16'h0001);
        cap_dout = dout[g];
        cap_err  = err[g];
        ren[g] = 1'b0; wen[g] = 1'b0;
        tick();
        check({tag, "/idle"}, 16'(bsy[g]), 16'h0000);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; ren[g] = 1'b0; wen[g] = 1'b0; addr[g] = 16'h0000; din[g] = 16'h0000;
        end
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst%0d/busy", g), 16'(bsy[g]), 16'h0000);
            check($sformatf("rst%0d/ready", g), 16'(rdy[g]), 16'h0000);
            check($sformatf("rst%0d/err", g), 16'(err[g]), 16'h0000);
            check($sformatf("rst%0d/dout", g), dout[g], 16'h0000);
            check($sformatf("rst%0d/io", g), iop[g], 16'h0000);
            rst[g] = 1'b0;
        end

        // Write then read back with one wait state.
        access(0, 1'b0, 1'b1, 16'h0012, 16'hBEEF, "w12");
        check("w12/err", 16'(cap_err), 16'h0000);
        access(0, 1'b1, 1'b0, 16'h0012, 16'h0000, "r12");
        check("r12/dout", cap_dout, 16'hBEEF);
        check("r12/err", 16'(cap_err), 16'h0000);
        check("r12/hold", dout[0], 16'hBEEF);

        // Simultaneous read and write is rejected without touching memory or data_out.
        access(0, 1'b0, 1'b1, 16'h0005, 16'h1111, "w05");
        access(0, 1'b1, 1'b1, 16'h0005, 16'h2222, "both");
        check("both/err", 16'(cap_err), 16'h0001);
        check("both/dout", cap_dout, 16'hBEEF);
        access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, "r05");
        check("r05/dout", cap_dout, 16'h1111);

        // Out-of-range addresses do not alias onto low memory.
        access(0, 1'b0, 1'b1, 16'h0000, 16'h0ABC, "w00");
        access(0, 1'b0, 1'b1, 16'h0100, 16'h1234, "w100");
        check("w100/err", 16'(cap_err), 16'h0001);
        access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, "r00");
        check("r00/dout", cap_dout, 16'h0ABC);
        check("r00/err", 16'(cap_err), 16'h0000);
        access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, "r100");
        check("r100/dout", cap_dout, 16'h0000);
        check("r100/err", 16'(cap_err), 16'h0001);

        // io_port at 16'hFFFF.
        access(0, 1'b0, 1'b1, 16'hFFFF, 16'h00A5, "wio");
`ifdef STUMP_MEM_IOPORT_EN
        check("wio/err", 16'(cap_err), 16'h0000);
        check("wio/io", iop[0], 16'h00A5);
`else
        check("wio/err", 16'(cap_err), 16'h0001);
        check("wio/io", iop[0], 16'h0000);
`endif
        access(0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, "rio");
`ifdef STUMP_MEM_IOPORT_EN
        check("rio/dout", cap_dout, 16'h00A5);
        check("rio/err", 16'(cap_err), 16'h0000);
`else
        check("rio/dout", cap_dout, 16'h0000);
        check("rio/err", 16'(cap_err), 16'h0001);
`endif

        // Zero wait states, back-to-back reads with mem_ren held high.
        for (int k = 0; k < 3; k++) begin
            access(1, 1'b0, 1'b1, 16'(k), 16'(16'h1000 + k), $sformatf("pre%0d", k));
        end
        ren[1] = 1'b1; addr[1] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("b2b%0d/ready", k), 16'(rdy[1]), 16'h0001);
            check($sformatf("b2b%0d/busy", k), 16'(bsy[1]), 16'h0001);
            check($sformatf("b2b%0d/dout", k), dout[1], 16'(16'h1000 + k));
            addr[1] = 16'(k + 1);
            tick();
            check($sformatf("b2b%0d/gap_ready", k), 16'(rdy[1]), 16'h0000);
            check($sformatf("b2b%0d/gap_busy", k), 16'(bsy[1]), 16'h0000);
        end
        ren[1] = 1'b0;

        // Reset in the second wait cycle abandons the write.
        access(2, 1'b0, 1'b1, 16'h0007, 16'h7777, "w07");
        wen[2] = 1'b1; addr[2] = 16'h0007; din[2] = 16'hDEAD;
        tick();
        check("abort/busy_w1", 16'(bsy[2]), 16'h0001);
        tick();
        check("abort/busy_w2", 16'(bsy[2]), 16'h0001);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0; wen[2] = 1'b0;
        check("abort/busy", 16'(bsy[2]), 16'h0000);
        check("abort/ready", 16'(rdy[2]), 16'h0000);
        tick();
        tick();
        check("abort/ready_late", 16'(rdy[2]), 16'h0000);
        access(2, 1'b1, 1'b0, 16'h0007, 16'h0000, "r07");
        check("r07/dout", cap_dout, 16'h7777);

        // Reset clears data_out but not the array.
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("rst2/dout", dout[0], 16'h0000);
        check("rst2/io", iop[0], 16'h0000);
        access(0, 1'b1, 1'b0, 16'h0012, 16'h0000, "r12b");
        check("r12b/dout", cap_dout, 16'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stump_mem_responder.md
STUMP_MEM_RESPONDER -- requirements
Module: stump_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, wait states inserted before each response (0..15).
REQ-002 Parameter ADDR_BITS, default 8, implemented word-address width; array depth = 2**ADDR_BITS words of 16 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_ren  input  1  read request from the Stump control path; held until mem_ready.
REQ-006 mem_wen  input  1  write request; held until mem_ready.
REQ-007 address  input  16  word address of the request.
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data.
REQ-010 mem_ready  output  1  one-cycle completion pulse for the current request.
REQ-011 mem_err  output  1  one-cycle error pulse, coincident with mem_ready.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 io_port  output  16  memory-mapped output register; present only with STUMP_MEM_IOPORT_EN, otherwise tied to 0.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; encoded in 2 bits.
REQ-015 IDLE: mem_ren or mem_wen high -> latch address, data_in, and request type; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT: a 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0 -> RESP; request inputs ignored.
REQ-017 RESP lasts exactly one cycle: mem_ready=1; write committed to array/io_port on the clock edge leaving RESP; next state IDLE.
REQ-018 Read: data_out updated from the array at the edge entering RESP, valid while mem_ready=1, and held until the next completed read.
REQ-019 Latency from request sampled in IDLE to mem_ready = WAIT_CYCLES+1 cycles.
REQ-020 After RESP, the block spends at least one cycle in IDLE; a request still asserted there starts a new access (back-to-back allowed).
REQ-021 mem_ren and mem_wen both high when sampled: no array access; mem_err=1 with mem_ready; data_out unchanged.
REQ-022 Address with any bit at or above ADDR_BITS set (excluding 16'hFFFF under STUMP_MEM_IOPORT_EN): write dropped; read returns 16'h0000; mem_err=1.
REQ-023 Requests deasserted during WAIT do not abort the access; the latched request completes.
REQ-024 Address wrap is not applied; out-of-range handling is governed by REQ-022 only.

Reset
REQ-025 rst=1 forces state IDLE, counter 0, mem_ready=0, mem_err=0, busy=0, data_out=16'h0000, io_port=16'h0000 on the next edge.
REQ-026 Reset during WAIT or RESP abandons the access; a pending write is not committed.
REQ-027 Array contents are not cleared by reset.

Configuration
REQ-028 Macro STUMP_MEM_IOPORT_EN defined: address 16'hFFFF selects the io_port register; writes load it; reads return its value; no mem_err.
REQ-029 Macro undefined: 16'hFFFF is treated as out of range per REQ-022; io_port is held at 0.

Verification
REQ-030 WAIT_CYCLES=1: write 16'hBEEF to 0x0012, then read 0x0012 -> mem_ready 2 cycles after each request; data_out=16'hBEEF with mem_ready.
REQ-031 WAIT_CYCLES=0: mem_ren held over 3 reads of 0x00,0x01,0x02 -> mem_ready every 2nd cycle; busy toggles 1,0.
REQ-032 mem_ren=mem_wen=1 at 0x0005 -> mem_ready=1, mem_err=1; a subsequent read of 0x0005 returns the prior contents.
REQ-033 ADDR_BITS=8: write 16'h1234 to 0x0100 -> mem_err=1; read of 0x0000 is unchanged; read of 0x0100 returns 16'h0000 with mem_err=1.
REQ-034 WAIT_CYCLES=3: write issued, rst pulsed in the 2nd WAIT cycle -> busy=0 on the next cycle, no mem_ready, target word unchanged.
REQ-035 With STUMP_MEM_IOPORT_EN: write 16'h00A5 to 0xFFFF -> io_port=16'h00A5 after RESP, mem_err=0; without the macro -> mem_err=1 and io_port=0.
